// File: rtl/rng_pkg.sv
// Shared constants and types for the multi-channel game RNG.
package rng_pkg;

    // Channel FSM encoding; also exported on the ch_state debug port.
    typedef logic [1:0] ch_state_t;
    localparam ch_state_t IDLE = 2'd0;
    localparam ch_state_t PEND = 2'd1;
    localparam ch_state_t DONE = 2'd2;

    // Maximal-length right-shift Galois tap masks.
    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_24 = 32'h00E1_0000;
    localparam logic [31:0] TAPS_32 = 32'hA300_0000;

    // Tap mask for a supported LFSR width (8, 16, 24 or 32).
    function automatic logic [31:0] taps(input int width);
        case (width)
            8:       taps = TAPS_8;
            16:      taps = TAPS_16;
            24:      taps = TAPS_24;
            default: taps = TAPS_32;
        endcase
    endfunction

endpackage

// File: rtl/rng_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last winner.
module rng_rr_arbiter #(
    parameter int N = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic [PTR_W-1:0] ptr;
    logic             found;

    // Pick the first requester at or above ptr, else wrap to the lowest index.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Move the priority pointer to the channel after the one just granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) ptr <= (i == N - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/rng_multi.sv
// Multi-channel range-limited PRNG: one shared Galois LFSR, per-channel draw FSMs.
//
// Handshake: req[c] is a level request. The FSM latches it when entering PEND;
// dropping req afterwards does not cancel the draw. When the draw resolves,
// valid[c] pulses for exactly one cycle and data[c] updates in that same
// cycle, then holds until the next valid. There is no back-pressure: the
// consumer must take data while valid is high or read the held value later.
module rng_multi
    import rng_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter int                CHANNELS  = 2,
    parameter longint unsigned   LIMIT     = 12,
    parameter int                MAX_RETRY = 3,
    parameter logic [WIDTH-1:0]  SEED      = WIDTH'(8'h9B),
    localparam int               OUT_W     = $clog2(LIMIT + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      seed_load,
    input  logic [WIDTH-1:0]          seed,
    input  logic [CHANNELS-1:0]       req,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS*OUT_W-1:0] data,
    output logic [WIDTH-1:0]          lfsr_state,
    output logic [2*CHANNELS-1:0]     ch_state
);

    localparam logic [WIDTH-1:0] TAPS      = WIDTH'(taps(WIDTH));
    localparam logic [OUT_W-1:0] LIM       = OUT_W'(LIMIT);
    // Fallback subtracts LIMIT+1; modulo-2^OUT_W arithmetic gives the exact
    // result because a rejected candidate is always above LIMIT.
    localparam logic [OUT_W-1:0] LIM_P1    = OUT_W'(LIMIT + 1);
    localparam logic [2:0]       RETRY_LIM = 3'(MAX_RETRY);

    logic [WIDTH-1:0]    state;
    logic [OUT_W-1:0]    cand;
    logic [OUT_W-1:0]    wrapped;
    logic                accept;
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] grant;

    // Free-running LFSR; reset, then reseed, take the place of the advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEED;
        end else if (seed_load) begin
            state <= (seed == '0) ? WIDTH'(1) : seed;
        end else if (state[0]) begin
            state <= (state >> 1) ^ TAPS;
        end else begin
            state <= state >> 1;
        end
    end

    assign lfsr_state = state;
    assign cand       = state[OUT_W-1:0];
    assign accept     = (cand <= LIM);
    assign wrapped    = cand - LIM_P1;

    rng_rr_arbiter #(.N(CHANNELS)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (pend),
        .grant (grant)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        ch_state_t        st;
        logic [2:0]       retry_cnt;
        logic [OUT_W-1:0] dreg;

        // Per-channel draw FSM with bounded rejection sampling.
        always_ff @(posedge clk) begin
            if (reset) begin
                st        <= IDLE;
                retry_cnt <= '0;
                dreg      <= '0;
            end else begin
                case (st)
                    IDLE: if (req[c]) st <= PEND;
                    PEND: begin
                        if (grant[c]) begin
                            if (accept) begin
                                dreg      <= cand;
                                st        <= DONE;
                                retry_cnt <= '0;
                            end else if (retry_cnt < RETRY_LIM) begin
                                retry_cnt <= retry_cnt + 3'd1;
                            end else begin
                                dreg      <= wrapped;
                                st        <= DONE;
                                retry_cnt <= '0;
                            end
                        end
                    end
                    DONE:    st <= req[c] ? PEND : IDLE;
                    default: st <= IDLE;
                endcase
            end
        end

        assign pend[c]                 = (st == PEND);
        assign valid[c]                = (st == DONE);
        assign data[c*OUT_W +: OUT_W]  = dreg;
        assign ch_state[2*c +: 2]      = st;
    end

endmodule

// File: tb/tb_rng_multi.sv
// Directed bench for rng_multi: three instances with different LIMIT/MAX_RETRY.
module tb_rng_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        seed_load;
    logic [7:0]  seed;
    logic [1:0]  req_a, req_b, req_c;
    logic [1:0]  valid_a, valid_b, valid_c;
    logic [15:0] data_a;
    logic [7:0]  data_b, data_c;
    logic [7:0]  lfsr_a, lfsr_b, lfsr_c;
    logic [3:0]  chs_a, chs_b, chs_c;

    // A: full-range output, seed 01. B: LIMIT 12 no retry. C: LIMIT 12, 3 retries.
    rng_multi #(.WIDTH(8), .CHANNELS(2), .LIMIT(255), .MAX_RETRY(3), .SEED(8'h01)) u_a (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .req(req_a),
        .valid(valid_a), .data(data_a), .lfsr_state(lfsr_a), .ch_state(chs_a));
    rng_multi #(.WIDTH(8), .CHANNELS(2), .LIMIT(12), .MAX_RETRY(0), .SEED(8'h9B)) u_b (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .req(req_b),
        .valid(valid_b), .data(data_b), .lfsr_state(lfsr_b), .ch_state(chs_b));
    rng_multi #(.WIDTH(8), .CHANNELS(2), .LIMIT(12), .MAX_RETRY(3), .SEED(8'h9B)) u_c (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .req(req_c),
        .valid(valid_c), .data(data_c), .lfsr_state(lfsr_c), .ch_state(chs_c));

    int         total = 0;
    int         bad   = 0;
    logic [7:0] ma;       // reference LFSR for instance A
    logic [7:0] mbc;      // reference LFSR for instances B and C
    logic [7:0] exp_q[$];
    int         ch_q[$];

    function automatic logic [7:0] step8(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    // Single-attempt draw in 0..12: accept or subtract 13.
    function automatic logic [7:0] draw12(input logic [7:0] s);
        logic [3:0] c4;
        c4 = s[3:0];
        return (c4 <= 4'd12) ? {4'd0, c4} : {4'd0, 4'(c4 - 4'd13)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, stepping the reference LFSRs with the driven inputs.
    task automatic tick();
        logic [7:0] na, nb;
        if (reset) begin
            na = 8'h01;
            nb = 8'h9B;
        end else if (seed_load) begin
            na = (seed == 8'h00) ? 8'h01 : seed;
            nb = na;
        end else begin
            na = step8(ma);
            nb = step8(mbc);
        end
        @(posedge clk);
        ma  = na;
        mbc = nb;
        #1;
    endtask

    task automatic sb_push(input logic [7:0] v, input int ch);
        exp_q.push_back(v);
        ch_q.push_back(ch);
    endtask

    // Pop the oldest expected draw and compare it to the observed valid/data.
    task automatic sb_pop(input string tag, input logic [1:0] v, input logic [15:0] d, input int ow);
        logic [7:0] e;
        int         ch;
        logic [15:0] mask;
        check({tag, "_avail"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e    = exp_q.pop_front();
            ch   = ch_q.pop_front();
            mask = 16'((1 << ow) - 1);
            check({tag, "_valid"}, 32'(v), 32'(1 << ch));
            check({tag, "_data"}, 32'((d >> (ch * ow)) & mask), 32'(e));
        end
    endtask

    initial begin
        logic [7:0] seq_exp[5];
        logic [7:0] held, s, ce;
        int         hits, r, lat, cyc;

        seq_exp = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        reset = 1'b1; seed_load = 1'b0; seed = 8'h00;
        req_a = 2'b00; req_b = 2'b00; req_c = 2'b00;
        tick();
        tick();

        // Reset values.
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_data_a",  32'(data_a),  32'd0);
        check("rst_fsm_a",   32'(chs_a),   32'd0);
        check("rst_data_b",  32'(data_b),  32'd0);
        check("rst_fsm_c",   32'(chs_c),   32'd0);
        check("rst_lfsr_a",  32'(lfsr_a),  32'h01);
        check("rst_lfsr_b",  32'(lfsr_b),  32'h9B);

        // Sequence and period from seed 01.
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("seq_%0d", i), 32'(lfsr_a), 32'(seq_exp[i]));
        end
        hits = 0;
        for (int n = 6; n <= 254; n++) begin
            tick();
            if (lfsr_a == 8'h01) hits++;
        end
        check("period_early", 32'(hits), 32'd0);
        tick();
        check("period_255", 32'(lfsr_a), 32'h01);

        // Single draw on channel 0.
        req_a = 2'b01;
        tick();
        req_a = 2'b00;
        check("t2_c1_valid", 32'(valid_a), 32'd0);
        held = ma;
        sb_push(ma, 0);
        tick();
        sb_pop("t2", valid_a, data_a, 8);
        tick();
        check("t2_c3_valid", 32'(valid_a), 32'd0);
        tick();
        tick();
        check("t2_hold", 32'(data_a), 32'(held));

        // Grant coinciding with seed_load uses the pre-load state.
        req_a = 2'b01;
        tick();
        req_a = 2'b00;
        seed_load = 1'b1; seed = 8'h3C;
        sb_push(ma, 0);
        tick();
        seed_load = 1'b0;
        sb_pop("t_preload", valid_a, data_a, 8);
        check("t_preload_lfsr", 32'(lfsr_a), 32'h3C);

        // Contention: both channels held, grants alternate from channel 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_a = 2'b11;
        tick();
        for (int n = 1; n <= 9; n++) begin
            if (n >= 2) sb_pop($sformatf("t3_%0d", n), valid_a, data_a, 8);
            sb_push(ma, (n - 1) % 2);
            if (n == 9) req_a = 2'b00;
            tick();
        end
        sb_pop("t3_last", valid_a, data_a, 8);
        tick();
        check("t3_quiet", 32'(valid_a), 32'd0);

        // Rejection: seed 0F gives cand 15 on the first grant.
        seed_load = 1'b1; seed = 8'h0F;
        req_b = 2'b01; req_c = 2'b01;
        tick();
        seed_load = 1'b0; req_b = 2'b00; req_c = 2'b00;
        sb_push(draw12(mbc), 0);
        s = mbc; r = 0; lat = 2;
        while ((s[3:0] > 4'd12) && (r < 3)) begin
            r++;
            s = step8(s);
            lat++;
        end
        ce = draw12(s);
        sb_push(ce, 0);
        tick();
        sb_pop("t4b", valid_b, {8'd0, data_b}, 4);
        check("t4b_fallback", 32'(data_b), 32'd2);
        cyc = 2;
        while ((valid_c == 2'b00) && (cyc < 20)) begin
            tick();
            cyc++;
        end
        check("t4c_lat", 32'(cyc), 32'(lat));
        sb_pop("t4c", valid_c, {8'd0, data_c}, 4);
        check("t4c_range", 32'(data_c[3:0] <= 4'd12), 32'd1);

        // Seed override and reset priority.
        tick();
        seed_load = 1'b1; seed = 8'h00;
        tick();
        seed_load = 1'b0;
        check("t5_zero_a", 32'(lfsr_a), 32'h01);
        check("t5_zero_b", 32'(lfsr_b), 32'h01);
        reset = 1'b1; seed_load = 1'b1; seed = 8'h55;
        tick();
        check("t5_rst_a", 32'(lfsr_a), 32'h01);
        check("t5_rst_b", 32'(lfsr_b), 32'h9B);
        reset = 1'b0; seed_load = 1'b0;

        // Reset while a repeat draw is pending.
        req_b = 2'b01;
        tick();
        sb_push(draw12(mbc), 0);
        tick();
        sb_pop("t6_draw", valid_b, {8'd0, data_b}, 4);
        tick();
        check("t6_pend", 32'(chs_b[1:0]), 32'd1);
        reset = 1'b1;
        tick();
        check("t6_valid", 32'(valid_b), 32'd0);
        check("t6_data",  32'(data_b),  32'd0);
        check("t6_fsm",   32'(chs_b),   32'd0);
        tick();
        check("t6_valid2", 32'(valid_b), 32'd0);
        reset = 1'b0; req_b = 2'b00;
        tick();
        check("t6_valid3", 32'(valid_b), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rng_multi.md
# rng_multi

Parametrised multi-channel pseudo-random number generator for game logic. One free-running Galois LFSR core is shared by CHANNELS independent consumers. Each channel draws through a request/valid handshake, served by a round-robin arbiter. Each draw is range-limited to 0..LIMIT by bounded rejection sampling with a guaranteed-in-range fallback.

## Interface
- WIDTH, 8: LFSR state width; legal values 8, 16, 24, 32.
- CHANNELS, 2: number of consumer channels; 1..8.
- LIMIT, 12: inclusive maximum output value; 1..2^WIDTH-1.
- MAX_RETRY, 3: rejected draws allowed before the fallback path; 0..7.
- SEED, 8'h9B (zero-extended to WIDTH): state loaded on reset; must be nonzero.
- OUT_W (derived): clog2(LIMIT+1).

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- seed_load  in  1  single-cycle pulse: load seed into the LFSR state.
- seed  in  WIDTH  reseed value.
- req  in  CHANNELS  per-channel draw request (level).
- valid  out  CHANNELS  one-cycle pulse: the channel's data was updated.
- data  out  CHANNELS*OUT_W  per-channel result; channel c occupies bits [c*OUT_W +: OUT_W]; held between draws.

## Operation
- **LFSR core:** a right-shift Galois LFSR advances every cycle, regardless of requests.
  - Update rule: if state[0]=1, next = (state>>1)^TAPS; otherwise next = state>>1.
  - Period is 2^WIDTH-1.
- **Seeding:**
  - reset loads SEED.
  - seed_load loads seed; a seed of 0 is replaced by 1, so all-zero lock-up is impossible.
  - The load replaces the LFSR advance in that cycle.
- **Channel FSM (per channel):** IDLE, PEND, DONE.
  - IDLE -> PEND when req[c]=1.
  - PEND: the channel is eligible for arbitration. On a grant, cand = state[OUT_W-1:0].
    - Accept if cand <= LIMIT.
    - Else, if retry_cnt < MAX_RETRY: increment retry_cnt and stay in PEND (draw again on a later grant).
    - Else: result = cand - (LIMIT+1). This is always <= LIMIT, because cand < 2^OUT_W <= 2*(LIMIT+1).
  - On accept or fallback: register data, go to DONE, clear retry_cnt.
  - DONE: valid[c]=1 for this one cycle. Then -> PEND if req[c]=1, else -> IDLE.
- **Handshake rules:**
  - A request is latched on entry to PEND. Dropping req while in PEND does not cancel the draw.
  - Holding req high produces back-to-back draws, one every two cycles minimum.
- **Arbitration:**
  - At most one PEND channel is granted per cycle.
  - Round-robin, starting after the last granted channel.
  - After reset, channel 0 has highest priority.
- **No-limit case:** LIMIT = 2^OUT_W-1 means no rejection ever occurs.
- **Simultaneous events:**
  - A grant in the same cycle as seed_load draws from the pre-load state.
  - reset overrides seed_load.

## Timing
- **Reset values:** valid=0; data=0; all FSMs IDLE; retry_cnt=0; arbiter pointer=0; state=SEED.
- **Reset mid-operation:** pending draws are discarded. No valid is issued for them.
- **Latency (uncontended, accepted first draw):**
  - req high in cycle 0.
  - PEND in cycle 1; grant evaluated in cycle 1.
  - valid and data present in cycle 2.
- **Additional latency:**
  - +1 cycle per rejection when uncontended.
  - Up to CHANNELS-1 extra cycles per attempt under contention.
  - Worst case is bounded by (MAX_RETRY+1)*CHANNELS+1 cycles.
- **Hold behaviour:** data changes only in the cycle where valid is high.

## Structure
- **Package rng_pkg:**
  - Tap constants: WIDTH 8 -> 8'hB8, 16 -> 16'hB400, 24 -> 24'hE10000, 32 -> 32'hA3000000.
  - Tap-select function taps(width).
  - Channel state typedef {IDLE, PEND, DONE}.
- **Sub-module rng_rr_arbiter:** CHANNELS-wide round-robin, one-hot grant, pointer register.
- **Top level:** LFSR, per-channel FSMs and retry counters (generate loop), output registers.

## Test plan
1. **Sequence check.** WIDTH=8, SEED=8'h01, LIMIT=255, no req.
   - Required: the state sequence after reset is B8, 5C, 2E, 17, B3.
   - Required: the state returns to 01 after exactly 255 cycles.
2. **Single draw.** req[0] pulsed in cycle 0.
   - Required: valid[0] high in cycle 2 only.
   - Required: data[0] equals the state sampled in cycle 1.
   - Required: valid[1] stays 0.
3. **Contention.** req=2'b11 held, LIMIT=255.
   - Required: grants alternate 0, 1, 0, 1.
   - Required: no channel ever waits more than 1 extra cycle.
   - Required: each valid is one cycle wide.
4. **Rejection and fallback.** LIMIT=12 (OUT_W=4), MAX_RETRY=0; seed_load with seed=8'h0F so that cand=15 on the first grant.
   - Required: data = 15-13 = 2, with no retry.
   - Repeat with MAX_RETRY=3. Required: the value is <= 12 and arrives after the retries.
5. **Seed override.** seed_load with seed=0.
   - Required: the next state is 01.
   - Required: with simultaneous reset, the state is SEED.
6. **Reset mid-draw.** req held, reset asserted while a channel is in PEND.
   - Required: no valid is issued.
   - Required: data=0 and the FSM is IDLE one cycle after reset.
